// File: rtl/cv32e40p_alu_ft_reconfig_ctrl_pkg.sv
// Shared types and configuration encodings for the fault-tolerant ALU
// reconfiguration controller (voter mux selects and input-pipe clock enables).
package cv32e40p_alu_ft_reconfig_ctrl_pkg;

    typedef enum logic [2:0] {
        ALU_FT_NORMAL   = 3'd0,
        ALU_FT_WAIT_RDY = 3'd1,
        ALU_FT_SWAP     = 3'd2,
        ALU_FT_DEGRADED = 3'd3,
        ALU_FT_FATAL    = 3'd4
    } alu_ft_state_e;

    localparam logic [2:0] ALU_FT_SEL_STBY  = 3'b111;
    localparam logic [2:0] ALU_FT_SEL_0     = 3'b110;
    localparam logic [2:0] ALU_FT_SEL_1     = 3'b101;
    localparam logic [2:0] ALU_FT_SEL_2     = 3'b011;

    localparam logic [3:0] ALU_FT_CKEN_STBY = 4'b0111;
    localparam logic [3:0] ALU_FT_CKEN_0    = 4'b1110;
    localparam logic [3:0] ALU_FT_CKEN_1    = 4'b1101;
    localparam logic [3:0] ALU_FT_CKEN_2    = 4'b1011;
    localparam logic [3:0] ALU_FT_CKEN_ALL  = 4'b1111;

    function automatic logic [2:0] alu_ft_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    return ALU_FT_SEL_0;
            2'd1:    return ALU_FT_SEL_1;
            2'd2:    return ALU_FT_SEL_2;
            default: return ALU_FT_SEL_STBY;
        endcase
    endfunction

    function automatic logic [3:0] alu_ft_cken(input logic [1:0] idx);
        case (idx)
            2'd0:    return ALU_FT_CKEN_0;
            2'd1:    return ALU_FT_CKEN_1;
            2'd2:    return ALU_FT_CKEN_2;
            default: return ALU_FT_CKEN_STBY;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40p_alu_ft_err_cnt.sv
// Per-replica leaky error counter: saturating count, threshold compare,
// sticky faulty flag and a one-cycle pulse on the cycle the flag latches.
module cv32e40p_alu_ft_err_cnt #(
    parameter int                   CNT_WIDTH = 9,
    parameter logic [CNT_WIDTH-1:0] THRESHOLD = 9'd255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 faulty_o,
    output logic                 latch_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 faulty_q, faulty_d;
    logic                 latch_q, latch_d;
    logic                 over_thr;

    always_comb begin
        over_thr = (cnt_q >= THRESHOLD);
        cnt_d    = cnt_q;
        // Increment wins over decay; a faulty counter is frozen.
        if (!faulty_q) begin
            if (inc_i) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
        faulty_d = faulty_q | over_thr;
        latch_d  = over_thr & ~faulty_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            faulty_q <= 1'b0;
            latch_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            faulty_q <= faulty_d;
            latch_q  <= latch_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign faulty_o = faulty_q;
    assign latch_o  = latch_q;

endmodule

// File: rtl/cv32e40p_alu_ft_reconfig_ctrl.sv
// Reconfiguration controller for the quad-replica ALU: tracks per-replica
// error counters and swaps a permanently faulty replica for the spare ALU3.
module cv32e40p_alu_ft_reconfig_ctrl
    import cv32e40p_alu_ft_reconfig_ctrl_pkg::*;
#(
    parameter int                   CNT_WIDTH    = 9,
    parameter logic [CNT_WIDTH-1:0] THRESHOLD    = 9'd255,
    parameter int                   DECAY_PERIOD = 1024,
    parameter int                   SWAP_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     ex_ready_i,
    input  logic [3:0]               err_detected_i,
    output logic [3:0]               clock_en_o,
    output logic [2:0]               sel_mux_ex_o,
    output logic [4*CNT_WIDTH-1:0]   permanent_faulty_alu_o,
    output logic [3:0]               perf_counter_permanent_faulty_alu_o,
    output logic                     reconfig_stall_o,
    output logic                     fatal_o
);
    localparam int               TMR_W    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DECAY_PERIOD - 1);
    localparam int               SWP_W    = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
    localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(SWAP_CYCLES - 1);

    alu_ft_state_e                 state_q, state_d;
    logic [1:0]                    target_q, target_d;
    logic [SWP_W-1:0]              swap_cnt_q, swap_cnt_d;
    logic [3:0]                    cken_q, cken_d;
    logic [2:0]                    sel_q, sel_d;
    logic                          stall_q, stall_d;
    logic                          fatal_q, fatal_d;
    logic [TMR_W-1:0]              tmr_q, tmr_d;
    logic                          decay_tick;
    logic [3:0]                    inc, faulty, latch;
    logic [3:0][CNT_WIDTH-1:0]     cnt;
    logic                          any_latch, multi_latch;

    // Only errors from clocked, still-healthy replicas are counted.
    assign inc = {4{enable_i}} & err_detected_i & cken_q & ~faulty;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        cv32e40p_alu_ft_err_cnt #(
            .CNT_WIDTH (CNT_WIDTH),
            .THRESHOLD (THRESHOLD)
        ) u_err_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .inc_i    (inc[g]),
            .dec_i    (decay_tick),
            .cnt_o    (cnt[g]),
            .faulty_o (faulty[g]),
            .latch_o  (latch[g])
        );
        assign permanent_faulty_alu_o[g*CNT_WIDTH +: CNT_WIDTH] =
            cnt[g] | {faulty[g], {(CNT_WIDTH-1){1'b0}}};
    end

    always_comb begin
        decay_tick = 1'b0;
        tmr_d      = tmr_q;
        if (|inc) begin
            tmr_d = '0;
        end else if (enable_i) begin
            if (tmr_q == TMR_LAST) begin
                tmr_d      = '0;
                decay_tick = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    assign any_latch   = |latch;
    assign multi_latch = (latch & (latch - 4'd1)) != 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALU_FT_NORMAL;
            target_q   <= 2'd0;
            swap_cnt_q <= '0;
            cken_q     <= ALU_FT_CKEN_STBY;
            sel_q      <= ALU_FT_SEL_STBY;
            stall_q    <= 1'b0;
            fatal_q    <= 1'b0;
            tmr_q      <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            swap_cnt_q <= swap_cnt_d;
            cken_q     <= cken_d;
            sel_q      <= sel_d;
            stall_q    <= stall_d;
            fatal_q    <= fatal_d;
            tmr_q      <= tmr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        swap_cnt_d = swap_cnt_q;
        case (state_q)
            ALU_FT_NORMAL: begin
                if (latch[3] || multi_latch) begin
                    state_d = ALU_FT_FATAL;
                end else if (any_latch) begin
                    state_d  = ALU_FT_WAIT_RDY;
                    target_d = latch[0] ? 2'd0 : (latch[1] ? 2'd1 : 2'd2);
                end
            end
            ALU_FT_WAIT_RDY: begin
                if (any_latch) begin
                    state_d = ALU_FT_FATAL;
                end else if (ex_ready_i) begin
                    state_d    = ALU_FT_SWAP;
                    swap_cnt_d = '0;
                end
            end
            ALU_FT_SWAP: begin
                if (any_latch)                    state_d = ALU_FT_FATAL;
                else if (swap_cnt_q == SWP_LAST)  state_d = ALU_FT_DEGRADED;
                else                              swap_cnt_d = swap_cnt_q + SWP_W'(1);
            end
            ALU_FT_DEGRADED: begin
                if (any_latch) state_d = ALU_FT_FATAL;
            end
            ALU_FT_FATAL:    state_d = ALU_FT_FATAL;
            default:         state_d = ALU_FT_NORMAL;
        endcase
    end

    // Leaving SWAP (to DEGRADED or FATAL) commits the target configuration.
    always_comb begin
        cken_d  = cken_q;
        sel_d   = sel_q;
        stall_d = 1'b0;
        fatal_d = fatal_q;
        if (state_d == ALU_FT_SWAP) begin
            cken_d  = ALU_FT_CKEN_ALL;
            stall_d = 1'b1;
        end else if (state_q == ALU_FT_SWAP) begin
            cken_d = alu_ft_cken(target_q);
            sel_d  = alu_ft_sel(target_q);
        end
        if (state_d == ALU_FT_FATAL) fatal_d = 1'b1;
    end

    assign clock_en_o                          = cken_q;
    assign sel_mux_ex_o                        = sel_q;
    assign perf_counter_permanent_faulty_alu_o = latch;
    assign reconfig_stall_o                    = stall_q;
    assign fatal_o                             = fatal_q;

endmodule
